// File: rtl/gate_tt_checker.sv
// Exhaustive truth-table checker for a 2-input NAND gate: sweeps ab = 00,10,01,11 and counts
// mismatches on dut_y. Define GATE_TT_FIRST_FAIL_EN to add first-mismatch capture (fail_vld/fail_vec).
module gate_tt_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_y,
    output logic       a_o,
    output logic       b_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [1:0] vec_idx
`ifdef GATE_TT_FIRST_FAIL_EN
    ,
    output logic       fail_vld,
    output logic [1:0] fail_vec
`endif
);

    typedef enum logic [0:0] {StIdle, StSettle} state_e;

    localparam logic [3:0] CntLoad  = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] PassLast = 3'(PASSES - 1);

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] pcnt_q, pcnt_d;
    logic [7:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       done_q, done_d;
    logic       expected;
    logic       mismatch;
    logic       sample;
    logic [7:0] err_nxt;

    // Expected value is derived from the vector currently on a_o/b_o.
    assign expected = ~(vec_q[0] & vec_q[1]);
    assign mismatch = (dut_y != expected);
    assign sample   = (state_q == StSettle) && !abort && (cnt_q == 4'd0);
    assign err_nxt  = (mismatch && err_q != 8'hff) ? err_q + 8'd1 : err_q;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        err_d   = err_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StSettle;
                    vec_d   = 2'd0;
                    cnt_d   = CntLoad;
                    pcnt_d  = 3'd0;
                    err_d   = 8'd0;
                    pass_d  = 1'b0;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                    vec_d   = 2'd0;
                    cnt_d   = 4'd0;
                    pcnt_d  = 3'd0;
                    pass_d  = 1'b0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_d = err_nxt;
                    vec_d = vec_q + 2'd1;
                    cnt_d = CntLoad;
                    if (vec_q == 2'd3) begin
                        if (pcnt_q == PassLast) begin
                            state_d = StIdle;
                            vec_d   = 2'd0;
                            cnt_d   = 4'd0;
                            pcnt_d  = 3'd0;
                            done_d  = 1'b1;
                            pass_d  = (err_nxt == 8'd0);
                        end else begin
                            pcnt_d = pcnt_q + 3'd1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            pcnt_q  <= 3'd0;
            err_q   <= 8'd0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    assign a_o     = vec_q[0];
    assign b_o     = vec_q[1];
    assign vec_idx = vec_q;
    assign busy    = (state_q == StSettle);
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;

`ifdef GATE_TT_FIRST_FAIL_EN
    logic       fail_vld_q, fail_vld_d;
    logic [1:0] fail_vec_q, fail_vec_d;

    // Cleared on an accepted start; an abort leaves the capture untouched.
    always_comb begin
        fail_vld_d = fail_vld_q;
        fail_vec_d = fail_vec_q;
        if (state_q == StIdle && start && !abort) begin
            fail_vld_d = 1'b0;
            fail_vec_d = 2'd0;
        end else if (sample && mismatch && !fail_vld_q) begin
            fail_vld_d = 1'b1;
            fail_vec_d = vec_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_vld_q <= 1'b0;
            fail_vec_q <= 2'd0;
        end else begin
            fail_vld_q <= fail_vld_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    assign fail_vld = fail_vld_q;
    assign fail_vec = fail_vec_q;
`endif

endmodule

// File: tb/tb_gate_tt_checker.sv
// Scoreboard bench for gate_tt_checker: per-cycle vector checks and per-run result checks,
// plus a second PASSES=8 instance for the long stuck-at-0 run.
module tb_gate_tt_checker;

    localparam int unsigned S  = 2;
    localparam int unsigned P  = 1;
    localparam int unsigned P8 = 8;

    typedef struct {
        int unsigned edge_n;
        logic [7:0]  err;
        logic        pass;
        logic        fvld;
        logic [1:0]  fvec;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dut_y;
    logic [1:0] mode = 2'd0;  // 0: ideal NAND, 1: stuck at 1, 2: stuck at 0
    logic       a_o, b_o, busy, done, pass;
    logic [7:0] err_cnt;
    logic [1:0] vec_idx;

    logic       start8 = 1'b0;
    logic       a8, b8, busy8, done8, pass8;
    logic [7:0] err8;
    logic [1:0] vec8;

`ifdef GATE_TT_FIRST_FAIL_EN
    logic       fail_vld, fail_vld8;
    logic [1:0] fail_vec, fail_vec8;
`endif

    logic [1:0]  vq[$];
    res_t        rq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;

    always_comb begin
        dut_y = 1'b0;
        case (mode)
            2'd0:    dut_y = ~(a_o & b_o);
            2'd1:    dut_y = 1'b1;
            default: dut_y = 1'b0;
        endcase
    end

    gate_tt_checker #(.SETTLE_CYCLES(S), .PASSES(P)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .dut_y   (dut_y),
        .a_o     (a_o),
        .b_o     (b_o),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt),
        .vec_idx (vec_idx)
`ifdef GATE_TT_FIRST_FAIL_EN
        ,
        .fail_vld(fail_vld),
        .fail_vec(fail_vec)
`endif
    );

    gate_tt_checker #(.SETTLE_CYCLES(S), .PASSES(P8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .abort   (1'b0),
        .dut_y   (1'b0),
        .a_o     (a8),
        .b_o     (b8),
        .busy    (busy8),
        .done    (done8),
        .pass    (pass8),
        .err_cnt (err8),
        .vec_idx (vec8)
`ifdef GATE_TT_FIRST_FAIL_EN
        ,
        .fail_vld(fail_vld8),
        .fail_vec(fail_vec8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model one run of the P=1 instance started so that it is accepted at accept_edge.
    task automatic push_run(input int unsigned accept_edge);
        res_t       r;
        logic [1:0] vv;
        logic       nd, y;
        r.err  = 8'd0;
        r.fvld = 1'b0;
        r.fvec = 2'd0;
        for (int p = 0; p < int'(P); p++) begin
            for (int v = 0; v < 4; v++) begin
                vv = 2'(v);
                for (int s = 0; s < int'(S); s++) vq.push_back(vv);
                nd = ~(vv[0] & vv[1]);
                y  = (mode == 2'd0) ? nd : (mode == 2'd1);
                if (y != nd) begin
                    if (!r.fvld) begin
                        r.fvld = 1'b1;
                        r.fvec = vv;
                    end
                    if (r.err != 8'hff) r.err = r.err + 8'd1;
                end
            end
        end
        r.pass   = (r.err == 8'd0);
        r.edge_n = accept_edge + 4 * S * P;
        rq.push_back(r);
    endtask

    task automatic wait_runs(input int bound);
        int k = 0;
        while (rq.size() != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (rq.size() != 0) begin
            check("timeout", rq.size(), 0);
            rq.delete();
            vq.delete();
        end
        check("vq_empty", vq.size(), 0);
    endtask

    always @(posedge clk) begin
        logic [1:0] v;
        res_t       r;
        cyc++;
        #1;
        if (rst_n) begin
            if (busy) begin
                if (vq.size() == 0) begin
                    check("extra_busy", 1, 0);
                end else begin
                    v = vq.pop_front();
                    check("vec_idx", vec_idx, v);
                    check("a_o", a_o, v[0]);
                    check("b_o", b_o, v[1]);
                    check("pass_busy", pass, 0);
                    check("done_busy", done, 0);
                end
            end else begin
                check("idle_vec", {a_o, b_o, vec_idx}, 0);
            end
            if (done) begin
                if (rq.size() == 0) begin
                    check("unexp_done", 1, 0);
                end else begin
                    r = rq.pop_front();
                    check("done_edge", cyc, r.edge_n);
                    check("err_cnt", err_cnt, r.err);
                    check("pass", pass, r.pass);
`ifdef GATE_TT_FIRST_FAIL_EN
                    check("fail_vld", fail_vld, r.fvld);
                    if (r.fvld) check("fail_vec", fail_vec, r.fvec);
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc;
        int          k;

        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_cnt, 0);
        check("rst_vec", {a_o, b_o, vec_idx}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Ideal gate
        mode = 2'd0;
        start = 1'b1;
        push_run(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        wait_runs(50);
        repeat (3) @(negedge clk);
        check("hold_pass_ideal", pass, 1);
        check("hold_err_ideal", err_cnt, 0);

        // Stuck at 1: only vector 3 mismatches
        mode = 2'd1;
        start = 1'b1;
        push_run(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        wait_runs(50);
        repeat (3) @(negedge clk);
        check("hold_err_s1", err_cnt, 1);
        check("hold_pass_s1", pass, 0);

        // Abort wins over start in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_idle_busy", busy, 0);
        check("abort_idle_err", err_cnt, 1);

        // Abort on the 5th edge after acceptance, stuck at 0
        mode = 2'd2;
        start = 1'b1;
        push_run(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vq.delete();
        rq.delete();
        check("abort_busy", busy, 0);
        check("abort_ab", {a_o, b_o, vec_idx}, 0);
        check("abort_err", err_cnt, 2);
        check("abort_pass", pass, 0);
        check("abort_done", done, 0);
        repeat (12) @(negedge clk);
        check("abort_err_hold", err_cnt, 2);

        // Reset mid-run
        start = 1'b1;
        push_run(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_err", err_cnt, 0);
        check("mrst_ab", {a_o, b_o, vec_idx}, 0);
        check("mrst_done_pass", {done, pass}, 0);
        vq.delete();
        rq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mode = 2'd0;
        start = 1'b1;
        push_run(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        wait_runs(50);
        @(negedge clk);
        check("mrst_clean_pass", pass, 1);

        // Start held high: second run accepted in the done cycle, third never
        start = 1'b1;
        push_run(cyc + 1);
        push_run(cyc + 1 + 4 * S * P + 1);
        repeat (4 * S * P + 3) @(negedge clk);
        start = 1'b0;
        wait_runs(60);
        repeat (4) @(negedge clk);
        check("b2b_no_third", busy, 0);
        check("b2b_pass", pass, 1);

        // PASSES=8, stuck at 0: three mismatches per pass
        start8 = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        start8 = 1'b0;
        k = 0;
        while (!done8 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("p8_done", done8, 1);
        check("p8_edge", cyc - acc, 4 * S * P8);
        check("p8_err", err8, 24);
        check("p8_pass", pass8, 0);
        check("p8_idle", {busy8, a8, b8, vec8}, 0);
`ifdef GATE_TT_FIRST_FAIL_EN
        check("p8_fail_vld", fail_vld8, 1);
        check("p8_fail_vec", fail_vec8, 0);
`endif
        @(negedge clk);
        check("p8_done_pulse", done8, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_tt_checker.md
GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning clocks a vector is held before dut_y is sampled; legal range 1..15.
REQ-002 SHALL have parameter PASSES, default 1, meaning full 4-vector sweeps per start; legal range 1..8.
REQ-003 SHALL have port clk  input  1  the only clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  request a run; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of a run.
REQ-007 SHALL have port dut_y  input  1  2-input NAND gate output under test.
REQ-008 SHALL have port a_o  output  1  gate input a, registered.
REQ-009 SHALL have port b_o  output  1  gate input b, registered.
REQ-010 SHALL have port busy  output  1  high while a run is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at normal run completion.
REQ-012 SHALL have port pass  output  1  high when the last completed run had zero mismatches.
REQ-013 SHALL have port err_cnt  output  8  mismatches in the current/last run, saturating.
REQ-014 SHALL have port vec_idx  output  2  index of the vector currently driven.

Function
REQ-015 SHALL implement states IDLE and SETTLE; done is a registered flag, not a state.
REQ-016 SHALL apply vectors in index order 0,1,2,3 with a_o=vec_idx[0] and b_o=vec_idx[1] (ab = 00,10,01,11).
REQ-017 SHALL compute expected = NOT(a_o AND b_o) for the vector being sampled.
REQ-018 SHALL, on an edge in IDLE with start=1 and abort=0: drive vector 0, set busy=1, clear err_cnt, clear pass, load settle counter with SETTLE_CYCLES-1, enter SETTLE.
REQ-019 SHALL, on each SETTLE edge with counter non-zero, decrement the counter only.
REQ-020 SHALL, on a SETTLE edge with counter zero, sample dut_y, increment err_cnt if dut_y differs from expected (saturating at 255), then advance to the next vector and reload the counter.
REQ-021 SHALL sample each vector exactly SETTLE_CYCLES edges after the edge that applied it.
REQ-022 SHALL wrap vec_idx 3->0 and increment the pass counter; after the sample of vector 3 in pass PASSES, return to IDLE.
REQ-023 SHALL, on that final sample edge, set done=1 for exactly one cycle, busy=0, a_o=b_o=0, vec_idx=0, and pass=1 iff the final err_cnt (including this sample) is 0.
REQ-024 SHALL take 4*SETTLE_CYCLES*PASSES edges from start acceptance to done assertion.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL accept start in the cycle done is high, since the state is IDLE then.
REQ-027 SHALL, on any edge with abort=1 in SETTLE, return to IDLE with busy=0, a_o=b_o=0, vec_idx=0, no done pulse, pass=0, and err_cnt holding its value.
REQ-028 SHALL give abort priority over start in IDLE and over the final sample; no done pulse results.
REQ-029 SHALL hold err_cnt and pass stable in IDLE until the next accepted start.

Reset
REQ-030 SHALL, while rst_n=0, force state=IDLE and a_o=b_o=busy=done=pass=0, err_cnt=0, vec_idx=0, with counters cleared.
REQ-031 SHALL abandon a run on reset mid-run without a done pulse and resume only on a new start after rst_n=1.

Configuration
REQ-032 SHALL, when macro GATE_TT_FIRST_FAIL_EN is defined, add outputs fail_vld (1) and fail_vec (2) that capture vec_idx of the first mismatch per run; these outputs clear on start and reset and hold until the next start.
REQ-033 SHALL, without GATE_TT_FIRST_FAIL_EN, omit fail_vld and fail_vec and add no capture logic.

Verification
REQ-034 SHALL cover: ideal NAND model, SETTLE_CYCLES=2, PASSES=1, start pulse -> a_o/b_o sequence 00,10,01,11 each for 2 cycles, done 8 edges after start, pass=1, err_cnt=0.
REQ-035 SHALL cover: dut_y stuck at 1 -> err_cnt=1 at done, pass=0, and with the macro fail_vld=1, fail_vec=3.
REQ-036 SHALL cover: dut_y stuck at 0, PASSES=8 -> err_cnt=24, pass=0, done at edge 64.
REQ-037 SHALL cover: abort on the 5th edge after start -> busy=0 next edge, no done, a_o=b_o=0, err_cnt held.
REQ-038 SHALL cover: rst_n dropped mid-run -> all outputs 0 immediately, then start after release gives a clean run with pass=1.
REQ-039 SHALL cover: start held high continuously -> back-to-back runs with the new run accepted in the done cycle; start during busy has no effect.
